// File: rtl/n64_apb_multi_interface.sv
`default_nettype none
// ============================================================================
// Module   : n64_apb_multi_interface
// Purpose  : APB3 slave that commands and reads up to NUM_CH N64 controller
//            engines. Each channel has an IDLE/RESETTING/POLLING state machine
//            with a timed reset pulse, a latched button word, a sticky change
//            register (read-to-clear) and an interrupt status bit. One level
//            interrupt is raised when any enabled channel's buttons change.
// Ports    : PCLK/PRESET          - clock, asynchronous active-high reset
//            PSEL..PWDATA         - APB3 request
//            PRDATA/PREADY/PSLVERR- APB3 response (PRDATA registered)
//            polling_enable[n]    - engine n polls continuously
//            controller_reset[n]  - engine n sends its reset byte
//            button_data/valid    - per-channel button samples (32b each)
//            irq                  - registered level interrupt
// Register map (byte address, [7:0] decoded):
//            0x10*n+0x0 CMD(W)/STATE(R), +0x4 BUTTONS(R), +0x8 CHANGED(R,RC)
//            0xF0 IRQ_STATUS (R, W1C), 0xF4 IRQ_ENABLE (R/W)
// Revision : 1.0 - initial release
// ============================================================================
module n64_apb_multi_interface #(
    parameter int NUM_CH       = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [NUM_CH-1:0]      polling_enable,
    output logic [NUM_CH-1:0]      controller_reset,
    input  logic [32*NUM_CH-1:0]   button_data,
    input  logic [NUM_CH-1:0]      button_valid,
    output logic                   irq
);

    localparam int                 c_CNT_W     = $clog2(RESET_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_RESET_CNT = c_CNT_W'(RESET_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_NUM_CH    = 4'(NUM_CH);
    // Channel slots addressable by PADDR[7:4]; unused slots read as zero.
    localparam int                 c_SLOTS     = 16;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RESETTING = 2'd1;
    localparam logic [1:0] c_POLLING   = 2'd2;

    localparam logic [31:0] c_CMD_RESET = 32'h0000_00FF;
    localparam logic [31:0] c_CMD_POLL  = 32'h0000_0001;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [7:0]  w_addr;
    logic [3:0]  w_ch_idx;
    logic [3:0]  w_reg_off;
    logic        w_is_ch;
    logic        w_is_status;
    logic        w_is_enable;
    logic        w_mapped;
    logic        w_access;
    logic        w_wr;
    logic        w_rd_access;
    logic        w_status_w1c;
    logic        w_unused_addr;

    assign w_addr        = PADDR[7:0];
    assign w_ch_idx      = w_addr[7:4];
    assign w_reg_off     = w_addr[3:0];
    assign w_is_ch       = (w_ch_idx < c_NUM_CH) &&
                           ((w_reg_off == 4'h0) || (w_reg_off == 4'h4) || (w_reg_off == 4'h8));
    assign w_is_status   = (w_addr == 8'hF0);
    assign w_is_enable   = (w_addr == 8'hF4);
    assign w_mapped      = w_is_ch || w_is_status || w_is_enable;
    assign w_access      = PSEL && PENABLE;
    assign w_wr          = w_access && PWRITE && w_mapped;
    assign w_rd_access   = w_access && !PWRITE;
    assign w_status_w1c  = w_wr && w_is_status;
    assign w_unused_addr = ^PADDR[31:8];

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access && !w_mapped;

    // Per-slot views used by the read mux
    logic [1:0]  w_state_all   [c_SLOTS];
    logic [31:0] w_buttons_all [c_SLOTS];
    logic [31:0] w_changed_all [c_SLOTS];
    logic [NUM_CH-1:0] w_diff_nz;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar n = 0; n < c_SLOTS; n++) begin : g_slot
        if (n < NUM_CH) begin : g_ch
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_CNT_W-1:0] w_cnt_nxt;
            logic [31:0]        r_buttons;
            logic [31:0]        r_changed;
            logic [31:0]        w_new;
            logic [31:0]        w_diff;
            logic               w_cmd_wr;
            logic               w_chg_rc;
            logic               w_cr;
            logic               w_pe;

            assign w_cmd_wr = w_wr && (w_ch_idx == 4'(n)) && (w_reg_off == 4'h0);
            assign w_chg_rc = w_rd_access && (w_ch_idx == 4'(n)) && (w_reg_off == 4'h8);
            assign w_new    = button_data[32*n +: 32];
            assign w_diff   = button_valid[n] ? (w_new ^ r_buttons) : 32'd0;

            // State register
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    r_state <= c_RESETTING;
                    r_cnt   <= c_RESET_CNT;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // Next state: a command always overrides the current state.
            // The counter is decremented on every RESETTING edge; leaving on
            // the edge where it hits zero gives exactly RESET_CYCLES cycles.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                if (w_cmd_wr) begin
                    if (PWDATA == c_CMD_RESET) begin
                        w_state_nxt = c_RESETTING;
                        w_cnt_nxt   = c_RESET_CNT;
                    end else if (PWDATA == c_CMD_POLL) begin
                        w_state_nxt = c_POLLING;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else begin
                    case (r_state)
                        c_IDLE:      w_state_nxt = c_IDLE;
                        c_POLLING:   w_state_nxt = c_POLLING;
                        c_RESETTING: begin
                            if (r_cnt <= c_CNT_ONE) begin
                                w_state_nxt = c_IDLE;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_cnt_nxt   = r_cnt - c_CNT_ONE;
                            end
                        end
                        default:     w_state_nxt = c_IDLE;
                    endcase
                end
            end

            // Outputs
            always_comb begin
                w_cr = (r_state == c_RESETTING);
                w_pe = (r_state == c_POLLING);
            end

            // Button capture; a read-clear in the same cycle keeps the new diff
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    r_buttons <= '0;
                    r_changed <= '0;
                end else begin
                    if (button_valid[n]) begin
                        r_buttons <= w_new;
                    end
                    if (w_chg_rc) begin
                        r_changed <= w_diff;
                    end else begin
                        r_changed <= r_changed | w_diff;
                    end
                end
            end

            assign controller_reset[n] = w_cr;
            assign polling_enable[n]   = w_pe;
            assign w_diff_nz[n]        = |w_diff;
            assign w_state_all[n]      = r_state;
            assign w_buttons_all[n]    = r_buttons;
            assign w_changed_all[n]    = r_changed;
        end else begin : g_pad
            assign w_state_all[n]   = 2'd0;
            assign w_buttons_all[n] = 32'd0;
            assign w_changed_all[n] = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt status / enable / read data
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] r_irq_status;
    logic [NUM_CH-1:0] r_irq_enable;
    logic [31:0]       w_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_is_status) begin
            w_rdata[NUM_CH-1:0] = r_irq_status;
        end else if (w_is_enable) begin
            w_rdata[NUM_CH-1:0] = r_irq_enable;
        end else if (w_is_ch) begin
            case (w_reg_off)
                4'h0:    w_rdata = {30'd0, w_state_all[w_ch_idx]};
                4'h4:    w_rdata = w_buttons_all[w_ch_idx];
                4'h8:    w_rdata = w_changed_all[w_ch_idx];
                default: w_rdata = '0;
            endcase
        end
    end

    // A new change sets the status even if firmware clears it this cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_irq_status <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_diff_nz[i]) begin
                    r_irq_status[i] <= 1'b1;
                end else if (w_status_w1c && PWDATA[i]) begin
                    r_irq_status[i] <= 1'b0;
                end
            end
        end
    end

    // PRDATA is captured at the setup edge so it is stable for the access phase.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_irq_enable <= '0;
            PRDATA       <= '0;
            irq          <= 1'b0;
        end else begin
            if (w_wr && w_is_enable) begin
                r_irq_enable <= PWDATA[NUM_CH-1:0];
            end
            if (PSEL && !PENABLE && !PWRITE) begin
                PRDATA <= w_rdata;
            end
            irq <= |(r_irq_status & r_irq_enable);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_n64_apb_multi_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_apb_multi_interface
// Purpose  : Directed self-checking bench. APB transactions push their
//            expected response into a queue; a monitor pops and compares it
//            during every access phase. Sideband outputs are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_apb_multi_interface;

    localparam int NUM_CH       = 4;
    localparam int RESET_CYCLES = 16;

    logic                 PCLK = 1'b0;
    logic                 PRESET = 1'b1;
    logic                 PSEL = 1'b0;
    logic                 PENABLE = 1'b0;
    logic                 PWRITE = 1'b0;
    logic [31:0]          PADDR = 32'd0;
    logic [31:0]          PWDATA = 32'd0;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;
    logic [NUM_CH-1:0]    polling_enable;
    logic [NUM_CH-1:0]    controller_reset;
    logic [32*NUM_CH-1:0] button_data = '0;
    logic [NUM_CH-1:0]    button_valid = '0;
    logic                 irq;

    n64_apb_multi_interface #(
        .NUM_CH       (NUM_CH),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .PSEL             (PSEL),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PADDR            (PADDR),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR),
        .polling_enable   (polling_enable),
        .controller_reset (controller_reset),
        .button_data      (button_data),
        .button_valid     (button_valid),
        .irq              (irq)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    logic        exp_rd   [$];
    logic [31:0] exp_data [$];
    logic        exp_err  [$];
    string       exp_name [$];

    // Scoreboard monitor: one expected entry per APB access phase
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && PREADY) begin
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access: addr=%h with empty scoreboard", PADDR);
            end else begin
                logic        e_rd;
                logic [31:0] e_data;
                logic        e_err;
                string       e_name;
                e_rd   = exp_rd.pop_front();
                e_data = exp_data.pop_front();
                e_err  = exp_err.pop_front();
                e_name = exp_name.pop_front();
                if ((PSLVERR !== e_err) || (e_rd && (PRDATA !== e_data))) begin
                    errors++;
                    $display("FAIL %s: got PRDATA=%h PSLVERR=%b, expected PRDATA=%h PSLVERR=%b (read=%b)",
                             e_name, PRDATA, PSLVERR, e_data, e_err, e_rd);
                end
            end
        end
    end

    task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Full APB transfer; optional button strobe driven during the access phase
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] e_data, input logic e_err, input string name,
                       input logic [NUM_CH-1:0] bv, input logic [32*NUM_CH-1:0] bd);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        exp_rd.push_back(!wr);
        exp_data.push_back(e_data);
        exp_err.push_back(e_err);
        exp_name.push_back(name);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (bv != '0) begin
            button_valid = bv;
            button_data  = bd;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        button_valid = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic e_err, input string name);
        apb(1'b1, addr, data, 32'd0, e_err, name, '0, button_data);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] e_data, input logic e_err, input string name);
        apb(1'b0, addr, 32'd0, e_data, e_err, name, '0, button_data);
    endtask

    task automatic pulse_bv(input logic [NUM_CH-1:0] bv, input logic [32*NUM_CH-1:0] bd);
        @(posedge PCLK); #1;
        button_valid = bv;
        button_data  = bd;
        @(posedge PCLK); #1;
        button_valid = '0;
    endtask

    initial begin
        // ---------------- reset state and release ----------------
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_sig("rst_controller_reset", 32'(controller_reset), 32'hF);
        check_sig("rst_polling_enable", 32'(polling_enable), 32'h0);
        check_sig("rst_irq", 32'(irq), 32'h0);
        check_sig("rst_prdata", PRDATA, 32'h0);
        check_sig("rst_pslverr", 32'(PSLVERR), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        for (int i = 0; i < RESET_CYCLES; i++) begin
            @(negedge PCLK);
            check_sig($sformatf("rel_cr_high_%0d", i), 32'(controller_reset), 32'hF);
        end
        @(negedge PCLK);
        check_sig("rel_cr_low", 32'(controller_reset), 32'h0);
        check_sig("rel_pe_low", 32'(polling_enable), 32'h0);
        check_sig("pready", 32'(PREADY), 32'h1);
        rd(32'h00, 32'h0, 1'b0, "state0_idle");
        rd(32'h10, 32'h0, 1'b0, "state1_idle");
        rd(32'h20, 32'h0, 1'b0, "state2_idle");
        rd(32'h30, 32'h0, 1'b0, "state3_idle");

        // ---------------- ch1 poll then reset ----------------
        wr(32'h10, 32'h01, 1'b0, "ch1_cmd_poll");
        @(negedge PCLK);
        check_sig("ch1_pe_on", 32'(polling_enable), 32'h2);
        check_sig("ch1_cr_off", 32'(controller_reset), 32'h0);
        rd(32'h10, 32'h2, 1'b0, "ch1_state_polling");
        wr(32'h10, 32'hFF, 1'b0, "ch1_cmd_reset");
        for (int i = 0; i < RESET_CYCLES; i++) begin
            @(negedge PCLK);
            check_sig($sformatf("ch1_cr_high_%0d", i), 32'(controller_reset), 32'h2);
        end
        check_sig("ch1_pe_off", 32'(polling_enable), 32'h0);
        @(negedge PCLK);
        check_sig("ch1_cr_done", 32'(controller_reset), 32'h0);
        rd(32'h10, 32'h0, 1'b0, "ch1_state_idle");

        // ---------------- ch2 buttons / changed / irq ----------------
        wr(32'hF4, 32'h4, 1'b0, "irq_enable_wr");
        rd(32'hF4, 32'h4, 1'b0, "irq_enable_rd");
        pulse_bv(4'b0100, 128'h1 << 64);
        @(negedge PCLK);
        check_sig("irq_latency_0", 32'(irq), 32'h0);
        @(negedge PCLK);
        check_sig("irq_latency_1", 32'(irq), 32'h1);
        pulse_bv(4'b0100, 128'h3 << 64);
        rd(32'h24, 32'h3, 1'b0, "ch2_buttons");
        rd(32'h28, 32'h3, 1'b0, "ch2_changed");
        rd(32'h28, 32'h0, 1'b0, "ch2_changed_cleared");
        check_sig("ch2_irq_high", 32'(irq), 32'h1);
        rd(32'hF0, 32'h4, 1'b0, "irq_status_ch2");
        wr(32'hF0, 32'h4, 1'b0, "irq_status_w1c");
        @(negedge PCLK);
        check_sig("irq_w1c_hold", 32'(irq), 32'h1);
        @(negedge PCLK);
        check_sig("irq_w1c_drop", 32'(irq), 32'h0);

        // ---------------- ch0 collisions ----------------
        pulse_bv(4'b0001, 128'h1);
        apb(1'b0, 32'h08, 32'd0, 32'h1, 1'b0, "ch0_changed_rc_collide", 4'b0001, 128'h21);
        rd(32'h08, 32'h20, 1'b0, "ch0_changed_survivor");
        rd(32'h08, 32'h0, 1'b0, "ch0_changed_empty");
        rd(32'h04, 32'h21, 1'b0, "ch0_buttons");
        rd(32'hF0, 32'h1, 1'b0, "irq_status_ch0");
        apb(1'b1, 32'hF0, 32'h1, 32'd0, 1'b0, "w1c_collide", 4'b0001, 128'h23);
        rd(32'hF0, 32'h1, 1'b0, "irq_status_set_wins");
        wr(32'hF0, 32'h1, 1'b0, "w1c_plain");
        rd(32'hF0, 32'h0, 1'b0, "irq_status_cleared");
        check_sig("irq_ch0_masked", 32'(irq), 32'h0);

        // ---------------- unmapped accesses ----------------
        rd(32'h50, 32'h0, 1'b1, "unmapped_rd_50");
        rd(32'h0C, 32'h0, 1'b1, "unmapped_rd_0c");
        wr(32'h84, 32'h01, 1'b1, "unmapped_wr_84");
        wr(32'h40, 32'h01, 1'b1, "unmapped_wr_ch4");
        check_sig("unmapped_pe", 32'(polling_enable), 32'h0);
        check_sig("unmapped_cr", 32'(controller_reset), 32'h0);
        rd(32'hF4, 32'h4, 1'b0, "irq_enable_kept");

        // ---------------- ch3 command overrides ----------------
        wr(32'h30, 32'h01, 1'b0, "ch3_poll");
        rd(32'h30, 32'h2, 1'b0, "ch3_state_polling");
        wr(32'h30, 32'h05, 1'b0, "ch3_other_cmd");
        rd(32'h30, 32'h0, 1'b0, "ch3_state_idle");
        wr(32'h30, 32'hFF, 1'b0, "ch3_reset");
        rd(32'h30, 32'h1, 1'b0, "ch3_state_resetting");
        wr(32'h30, 32'h01, 1'b0, "ch3_abort_poll");
        @(negedge PCLK);
        check_sig("ch3_abort_cr", 32'(controller_reset), 32'h0);
        check_sig("ch3_abort_pe", 32'(polling_enable), 32'h8);

        // ---------------- asynchronous reset mid-operation ----------------
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        check_sig("async_rst_cr", 32'(controller_reset), 32'hF);
        check_sig("async_rst_pe", 32'(polling_enable), 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        repeat (RESET_CYCLES) @(posedge PCLK);
        @(negedge PCLK);
        check_sig("async_rst_done", 32'(controller_reset), 32'h0);
        rd(32'hF4, 32'h0, 1'b0, "async_rst_enable");
        rd(32'h04, 32'h0, 1'b0, "async_rst_buttons");

        repeat (2) @(posedge PCLK);
        checks++;
        if (exp_rd.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_rd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/n64_apb_multi_interface.md
# n64_apb_multi_interface

APB3 slave that controls and reads up to eight N64 controller engines from the SmartFusion Cortex-M3 fabric interface, the multi-port successor of the single-controller APB block. Each channel has its own command/state machine with a timed reset pulse, a latched button word, a change-detect register and an interrupt source. A single level interrupt tells firmware when any enabled controller's buttons change, so firmware does not have to poll over APB.

## Interface
- NUM_CH, 4, number of controller channels, 1..8
- RESET_CYCLES, 16, PCLK cycles controller_reset is held per reset command, >=1
- PCLK  in  1  APB clock; all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  peripheral select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PADDR  in  32  byte address; only [7:0] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  error on unmapped access
- polling_enable  out  NUM_CH  per channel: engine polls continuously
- controller_reset  out  NUM_CH  per channel: engine sends 0xFF reset byte
- button_data  in  32*NUM_CH  channel n in bits [32n+31:32n]
- button_valid  in  NUM_CH  1-cycle strobe: channel n button_data is a fresh sample
- irq  out  1  level interrupt to fabric

## Operation
- Register map, channel n (n < NUM_CH), base 0x10*n: +0x0 CMD (W) / STATE (R, [1:0] = state code); +0x4 BUTTONS (R); +0x8 CHANGED (R, read-to-clear).
- Globals: 0xF0 IRQ_STATUS (R; W1C on bits [NUM_CH-1:0]); 0xF4 IRQ_ENABLE (R/W, [NUM_CH-1:0]).
- Any other address, or a channel base with n >= NUM_CH: PSLVERR=1 in access phase, write ignored, PRDATA=0.
- Per-channel FSM, codes IDLE=0, RESETTING=1, POLLING=2:
  - CMD 0xFF: go to RESETTING, load counter with RESETTING_CYCLES-1... precisely RESET_CYCLES; controller_reset=1 while RESETTING; when counter reaches 0, go to IDLE.
  - CMD 0x01: go to POLLING; polling_enable=1 only in POLLING.
  - Any other CMD value: go to IDLE.
  - Commands are accepted in every state and override it (0x01 during RESETTING aborts the pulse; 0xFF during RESETTING restarts the count).
- Button capture: on button_valid[n], BUTTONS[n] <= button_data[n]; diff = new ^ old BUTTONS[n]; CHANGED[n] |= diff; if diff != 0, IRQ_STATUS[n] <= 1. button_valid is honoured in every state.
- irq = |(IRQ_STATUS & IRQ_ENABLE), registered.
- Simultaneous events, same cycle:
  - Read-clear of CHANGED[n] plus new diff: CHANGED[n] <= diff (new bits survive).
  - W1C of IRQ_STATUS[n] plus new diff on n: the bit stays 1 (set wins).
- Reset (PRESET=1, any time, including mid-command): all channels RESETTING with counter = RESET_CYCLES, controller_reset all 1, polling_enable 0, BUTTONS/CHANGED/IRQ_STATUS/IRQ_ENABLE 0, PRDATA 0, irq 0, PSLVERR 0.
  - After release, controller_reset is held RESET_CYCLES cycles, then all channels are IDLE.

## Timing
- Setup phase (PSEL & !PENABLE & !PWRITE): PRDATA is loaded from the decoded register at the following edge, so it is valid throughout the access phase. PREADY is always 1.
- Write commit and read-to-clear occur on the access-phase edge (PSEL & PENABLE).
- FSM output change visible the cycle after the write edge. A RESETTING pulse lasts exactly RESET_CYCLES cycles.
- button_valid to BUTTONS readable: 1 cycle. button_valid to irq high: 2 cycles (status edge, then irq register).
- PSLVERR is combinational from the address decode, qualified by PSEL & PENABLE.

## Test plan
- Reset release, NUM_CH=4, RESET_CYCLES=16:
  - controller_reset=4'hF for exactly 16 cycles after PRESET falls, then 4'h0.
  - polling_enable=0; STATE reads 0 on all channels.
- Write 0x01 to 0x10, then 0xFF to 0x10, with the second write 3 cycles into POLLING:
  - polling_enable[1] rises 1 cycle after the first write and falls after the second.
  - controller_reset[1] is high 16 cycles; other channels are unaffected.
- IRQ_ENABLE=0x4; ch2 button_valid with 0x0000_0001, then 0x0000_0003:
  - BUTTONS[2]=3; CHANGED reads 0x3 and then 0x0 on re-read; irq=1.
  - W1C 0x4 to 0xF0 drops irq the cycle after.
- Same-cycle collision on ch0: CHANGED read-clear together with button_valid changing bit 5 -> next CHANGED read returns 0x20.
- Same-cycle collision on ch0: W1C of IRQ_STATUS together with a new diff -> IRQ_STATUS[0] remains 1.
- Unmapped access, read of 0x50 with NUM_CH=4 -> PSLVERR=1 and PRDATA=0.
- Unmapped access, write to 0x84 -> PSLVERR=1, no state change.
